// File: rtl/snake_move_ctrl.sv
// Game-tick sequencer for the snake body FIFO: builds the initial body, then on
// each tick computes the next head, checks the walls and drives push/pop strobes.
module snake_move_ctrl #(
  parameter int GRID_W   = 80,
  parameter int GRID_H   = 60,
  parameter int XW       = 7,
  parameter int YW       = 6,
  parameter int START_X  = 40,
  parameter int START_Y  = 30,
  parameter int INIT_LEN = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iTick,
  input  logic              iUpButton,
  input  logic              iDownButton,
  input  logic              iLeftButton,
  input  logic              iRightButton,
  input  logic              iGrow,
  input  logic              iRestart,
  input  logic              iBufFull,
  input  logic              iBufEmpty,
  input  logic [XW+YW-1:0]  iBufOut,
  output logic [XW+YW-1:0]  oBufIn,
  output logic              oWrEn,
  output logic              oRdEn,
  output logic              oFifoRst,
  output logic [XW-1:0]     oHeadX,
  output logic [YW-1:0]     oHeadY,
  output logic [XW-1:0]     oTailX,
  output logic [YW-1:0]     oTailY,
  output logic              oTailValid,
  output logic [XW+YW-1:0]  oLength,
  output logic [1:0]        oDir,
  output logic              oDead,
  output logic              oBusy,
  output logic [2:0]        dbg_state
);

  localparam int LW = XW + YW;

  localparam logic [1:0] DIR_UP    = 2'b11;
  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);
  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(START_X - INIT_LEN + 1);
  localparam logic [LW-1:0] K_LAST  = LW'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    FLUSH, INIT, IDLE, CALC, POP, TAIL, PUSH, DEAD
  } state_t;

  state_t          state;
  logic [XW-1:0]   head_x, nxt_x_q, nxt_x, tail_x;
  logic [YW-1:0]   head_y, nxt_y_q, nxt_y, tail_y;
  logic [LW-1:0]   length, k_q, buf_in;
  logic [1:0]      dir_q, pend_dir, btn_dir;
  logic            wr_en, rd_en, fifo_rst, tail_valid, dead;
  logic            grow_pending, popped, wall, btn_hit, dir_ok;
  logic [3:0]      sync1, sync2, sync3, btn_edge;

  // Button order {up, down, left, right}; sync3 is the previous synchronised value.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {iUpButton, iDownButton, iLeftButton, iRightButton};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign btn_edge = sync2 & ~sync3;

  always_comb begin
    btn_hit = 1'b1;
    btn_dir = DIR_RIGHT;
    if (btn_edge[3])      btn_dir = DIR_UP;
    else if (btn_edge[2]) btn_dir = DIR_DOWN;
    else if (btn_edge[1]) btn_dir = DIR_LEFT;
    else if (btn_edge[0]) btn_dir = DIR_RIGHT;
    else                  btn_hit = 1'b0;
  end

  // The direction encoding makes a reversal exactly the bitwise complement.
  assign dir_ok = btn_hit && (btn_dir != ~dir_q);

  always_comb begin
    nxt_x = head_x;
    nxt_y = head_y;
    wall  = 1'b0;
    case (pend_dir)
      DIR_UP: begin
        if (head_y == '0) wall = 1'b1;
        else              nxt_y = head_y - YW'(1);
      end
      DIR_DOWN: begin
        if (head_y >= Y_MAX) wall = 1'b1;
        else                 nxt_y = head_y + YW'(1);
      end
      DIR_LEFT: begin
        if (head_x == '0) wall = 1'b1;
        else              nxt_x = head_x - XW'(1);
      end
      default: begin
        if (head_x >= X_MAX) wall = 1'b1;
        else                 nxt_x = head_x + XW'(1);
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= FLUSH;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      fifo_rst     <= 1'b0;
      tail_valid   <= 1'b0;
      buf_in       <= '0;
      head_x       <= X_START;
      head_y       <= Y_START;
      nxt_x_q      <= X_START;
      nxt_y_q      <= Y_START;
      tail_x       <= '0;
      tail_y       <= '0;
      length       <= '0;
      k_q          <= '0;
      dir_q        <= DIR_RIGHT;
      pend_dir     <= DIR_RIGHT;
      dead         <= 1'b0;
      grow_pending <= 1'b0;
      popped       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      fifo_rst   <= 1'b0;
      tail_valid <= 1'b0;
      if (dir_ok) pend_dir <= btn_dir;
      if (iGrow)  grow_pending <= 1'b1;

      case (state)
        FLUSH: begin
          fifo_rst <= 1'b1;
          k_q      <= '0;
          state    <= INIT;
        end
        // Body is laid out left of the start cell so the last push is the head.
        INIT: begin
          wr_en  <= 1'b1;
          buf_in <= {Y_START, X_FIRST + k_q[XW-1:0]};
          k_q    <= k_q + LW'(1);
          length <= length + LW'(1);
          if (k_q == K_LAST) state <= IDLE;
        end
        IDLE: begin
          if (iTick) state <= CALC;
        end
        CALC: begin
          dir_q   <= pend_dir;
          nxt_x_q <= nxt_x;
          nxt_y_q <= nxt_y;
          buf_in  <= {nxt_y, nxt_x};
          if (wall) begin
            dead  <= 1'b1;
            state <= DEAD;
          end else if (grow_pending && !iBufFull) begin
            grow_pending <= 1'b0;
            popped       <= 1'b0;
            wr_en        <= 1'b1;
            state        <= PUSH;
          end else begin
            popped <= !iBufEmpty;
            rd_en  <= !iBufEmpty;
            state  <= POP;
          end
        end
        POP: begin
          if (popped) begin
            state <= TAIL;
          end else begin
            wr_en <= 1'b1;
            state <= PUSH;
          end
        end
        TAIL: begin
          tail_y     <= iBufOut[LW-1:XW];
          tail_x     <= iBufOut[XW-1:0];
          tail_valid <= 1'b1;
          wr_en      <= 1'b1;
          state      <= PUSH;
        end
        // Body grows whenever nothing was popped (grow, or pop skipped on empty).
        PUSH: begin
          head_x <= nxt_x_q;
          head_y <= nxt_y_q;
          if (!popped) length <= length + LW'(1);
          state  <= IDLE;
        end
        DEAD: begin
          if (iRestart) begin
            head_x       <= X_START;
            head_y       <= Y_START;
            dir_q        <= DIR_RIGHT;
            pend_dir     <= DIR_RIGHT;
            grow_pending <= 1'b0;
            length       <= '0;
            dead         <= 1'b0;
            state        <= FLUSH;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

  assign oBufIn     = buf_in;
  assign oWrEn      = wr_en;
  assign oRdEn      = rd_en;
  assign oFifoRst   = fifo_rst;
  assign oHeadX     = head_x;
  assign oHeadY     = head_y;
  assign oTailX     = tail_x;
  assign oTailY     = tail_y;
  assign oTailValid = tail_valid;
  assign oLength    = length;
  assign oDir       = dir_q;
  assign oDead      = dead;
  assign oBusy      = (state != IDLE) && (state != DEAD);
  assign dbg_state  = state;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with a small behavioural body FIFO attached.
module tb_snake_move_ctrl;
  localparam int XW = 7;
  localparam int YW = 6;
  localparam int LW = XW + YW;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, grow = 1'b0, restart = 1'b0;
  logic [3:0] btn = 4'b0;
  logic buf_full = 1'b0, buf_empty = 1'b1;
  logic [LW-1:0] buf_out = '0;
  logic [LW-1:0] buf_in, length;
  logic wr_en, rd_en, fifo_rst, tail_valid, dead, busy;
  logic [XW-1:0] head_x, tail_x;
  logic [YW-1:0] head_y, tail_y;
  logic [1:0] dir;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  snake_move_ctrl dut (
    .iCLK(clk), .iRST_N(rst_n), .iTick(tick),
    .iUpButton(btn[3]), .iDownButton(btn[2]), .iLeftButton(btn[1]), .iRightButton(btn[0]),
    .iGrow(grow), .iRestart(restart), .iBufFull(buf_full), .iBufEmpty(buf_empty),
    .iBufOut(buf_out), .oBufIn(buf_in), .oWrEn(wr_en), .oRdEn(rd_en), .oFifoRst(fifo_rst),
    .oHeadX(head_x), .oHeadY(head_y), .oTailX(tail_x), .oTailY(tail_y),
    .oTailValid(tail_valid), .oLength(length), .oDir(dir), .oDead(dead), .oBusy(busy),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] pk(input int x, input int y);
    logic [XW-1:0] xv;
    logic [YW-1:0] yv;
    xv = XW'(x);
    yv = YW'(y);
    return {yv, xv};
  endfunction

  // Body FIFO model and strobe monitor, sampled on the inactive edge.
  logic [LW-1:0] fifo_q[$];
  logic [LW-1:0] wr_log[$];
  logic [LW-1:0] tail_log[$];
  int n_wr = 0, n_rd = 0, n_flush = 0, n_both = 0;

  always @(negedge clk) begin
    if (wr_en && rd_en) n_both++;
    if (fifo_rst) begin
      fifo_q.delete();
      n_flush++;
    end else begin
      if (rd_en) begin
        n_rd++;
        if (fifo_q.size() > 0) buf_out = fifo_q.pop_front();
      end
      if (wr_en) begin
        n_wr++;
        wr_log.push_back(buf_in);
        if (fifo_q.size() < DEPTH) fifo_q.push_back(buf_in);
      end
    end
    if (tail_valid) tail_log.push_back({tail_y, tail_x});
    buf_full  = (fifo_q.size() == DEPTH);
    buf_empty = (fifo_q.size() == 0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (4) step();
    btn[b] = 1'b0;
    repeat (4) step();
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    step();
    grow = 1'b0;
  endtask

  // One tick; lat = cycles from tick to the push strobe.
  task automatic do_move(output int lat);
    int wr0;
    wr0 = n_wr;
    tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    while (n_wr == wr0 && lat < 12) begin
      step();
      lat++;
    end
    check_eq("move_push", n_wr - wr0, 1);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bad, w0, r0, f0;

    // Reset state
    step(); step();
    check_eq("rst_head_x", head_x, 40);
    check_eq("rst_head_y", head_y, 30);
    check_eq("rst_length", length, 0);
    check_eq("rst_dir", dir, 1);
    check_eq("rst_dead", dead, 0);
    check_eq("rst_strobes", {wr_en, rd_en, fifo_rst, tail_valid}, 0);
    check_eq("rst_busy", busy, 1);

    // Initial body build
    rst_n = 1'b1;
    repeat (6) step();
    check_eq("init_busy", busy, 0);
    check_eq("init_flush", n_flush, 1);
    check_eq("init_wr", n_wr, 4);
    check_eq("init_len", length, 4);
    check_eq("init_c0", wr_log[0], pk(37, 30));
    check_eq("init_c1", wr_log[1], pk(38, 30));
    check_eq("init_c2", wr_log[2], pk(39, 30));
    check_eq("init_c3", wr_log[3], pk(40, 30));

    // Three plain moves right
    for (int i = 0; i < 3; i++) begin
      do_move(lat);
      check_eq("move_lat", lat, 4);
    end
    check_eq("mv_head_x", head_x, 43);
    check_eq("mv_head_y", head_y, 30);
    check_eq("mv_len", length, 4);
    check_eq("mv_rd", n_rd, 3);
    check_eq("mv_tail_n", tail_log.size(), 3);
    check_eq("mv_tail0", tail_log[0], pk(37, 30));
    check_eq("mv_tail1", tail_log[1], pk(38, 30));
    check_eq("mv_tail2", tail_log[2], pk(39, 30));

    // Grow move then a normal move
    pulse_grow();
    do_move(lat);
    check_eq("grow_lat", lat, 2);
    check_eq("grow_rd", n_rd, 3);
    check_eq("grow_push", wr_log[7], pk(44, 30));
    check_eq("grow_len", length, 5);
    do_move(lat);
    check_eq("after_grow_lat", lat, 4);
    check_eq("after_grow_rd", n_rd, 4);
    check_eq("after_grow_tail", tail_log[3], pk(40, 30));
    check_eq("after_grow_len", length, 5);
    check_eq("after_grow_x", head_x, 45);

    // Reversal dropped, then turn up
    press(1);
    check_eq("rev_dir", dir, 1);
    do_move(lat);
    check_eq("rev_head_x", head_x, 46);
    check_eq("rev_dir2", dir, 1);
    press(3);
    do_move(lat);
    check_eq("up_dir", dir, 3);
    check_eq("up_head_y", head_y, 29);
    check_eq("up_head_x", head_x, 46);

    // Run right into the wall
    press(0);
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      do_move(lat);
      if (lat != 4) bad++;
    end
    check_eq("run_bad_lat", bad, 0);
    check_eq("run_head_x", head_x, 79);
    check_eq("run_dir", dir, 1);
    check_eq("run_len", length, 5);
    w0 = n_wr;
    r0 = n_rd;
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (6) step();
    check_eq("wall_dead", dead, 1);
    check_eq("wall_no_wr", n_wr, w0);
    check_eq("wall_no_rd", n_rd, r0);
    check_eq("wall_head_x", head_x, 79);
    check_eq("wall_busy", busy, 0);

    // Restart
    f0 = n_flush;
    w0 = n_wr;
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (7) step();
    check_eq("rs_flush", n_flush, f0 + 1);
    check_eq("rs_wr", n_wr, w0 + 4);
    check_eq("rs_first", wr_log[w0], pk(37, 30));
    check_eq("rs_last", wr_log[w0 + 3], pk(40, 30));
    check_eq("rs_dead", dead, 0);
    check_eq("rs_head", {head_y, head_x}, pk(40, 30));
    check_eq("rs_len", length, 4);
    check_eq("rs_dir", dir, 1);
    check_eq("rs_busy", busy, 0);

    // Tick held through a whole move: only the first is accepted
    w0 = n_wr;
    tick = 1'b1;
    repeat (5) step();
    tick = 1'b0;
    repeat (3) step();
    check_eq("hold_wr", n_wr, w0 + 1);
    check_eq("hold_head_x", head_x, 41);
    check_eq("hold_busy", busy, 0);

    // Reset asserted during POP
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check_eq("pop_rd", rd_en, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_strobes", {wr_en, rd_en, fifo_rst, tail_valid}, 0);
    check_eq("abort_head", {head_y, head_x}, pk(40, 30));
    check_eq("abort_len", length, 0);
    check_eq("abort_busy", busy, 1);
    check_eq("abort_dir", dir, 1);
    f0 = n_flush;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_eq("reinit_flush", n_flush, f0 + 1);
    check_eq("reinit_len", length, 4);
    check_eq("reinit_head", {head_y, head_x}, pk(40, 30));
    check_eq("reinit_busy", busy, 0);

    check_eq("wr_rd_overlap", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
